// File: rtl/tmds_channel_decoder.sv
// TMDS receive channel: word alignment via ISERDES bitslip plus 10b->8b decode.
// Lock is declared after LockCount consecutive control tokens. Without lock,
// the aligner slips one bit every SearchWindow+1+SlipWait cycles. Lock is lost
// after MaxDataRun consecutive data symbols.
module tmds_channel_decoder #(
  parameter int LockCount    = 8,
  parameter int SearchWindow = 4096,
  parameter int SlipWait     = 3,
  parameter int MaxDataRun   = 4096
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [9:0] tmds_i,
  output logic       bitslip_o,
  output logic       locked_o,
  output logic [7:0] data_o,
  output logic       de_o,
  output logic [1:0] ctrl_o
);

  localparam int TokW  = $clog2(LockCount + 1);
  localparam int WinW  = $clog2(SearchWindow + 1);
  localparam int WaitW = $clog2(SlipWait + 1);
  localparam int RunW  = $clog2(MaxDataRun + 1);

  typedef enum logic [1:0] {SEARCH, SLIP, WAIT, LOCKED} state_t;

  state_t           state_q, state_d;
  logic [TokW-1:0]  tok_q, tok_d;
  logic [WinW-1:0]  win_q, win_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic [RunW-1:0]  run_q, run_d;

  logic       is_tok;
  logic [1:0] tok_val;
  logic [7:0] dsym;
  logic [7:0] dec;

  // Undo the optional inversion applied by the encoder (bit 9).
  assign dsym = tmds_i[9] ? ~tmds_i[7:0] : tmds_i[7:0];

  // Recognise the four DVI control tokens.
  always_comb begin
    is_tok  = 1'b1;
    tok_val = 2'b00;
    case (tmds_i)
      10'h354: tok_val = 2'b00;
      10'h0AB: tok_val = 2'b01;
      10'h154: tok_val = 2'b10;
      10'h2AB: tok_val = 2'b11;
      default: is_tok = 1'b0;
    endcase
  end

  // Undo the XOR/XNOR transition chain (bit 8 selects XOR).
  always_comb begin
    dec    = '0;
    dec[0] = dsym[0];
    for (int i = 1; i < 8; i++)
      dec[i] = tmds_i[8] ? (dsym[i] ^ dsym[i-1]) : ~(dsym[i] ^ dsym[i-1]);
  end

  // Aligner state and counters.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= SEARCH;
      tok_q   <= '0;
      win_q   <= '0;
      wait_q  <= '0;
      run_q   <= '0;
    end else begin
      state_q <= state_d;
      tok_q   <= tok_d;
      win_q   <= win_d;
      wait_q  <= wait_d;
      run_q   <= run_d;
    end
  end

  // Next-state logic.
  // A lock-completing token wins over window expiry in the same cycle.
  always_comb begin
    state_d = state_q;
    tok_d   = tok_q;
    win_d   = win_q;
    wait_d  = wait_q;
    run_d   = run_q;
    case (state_q)
      SEARCH: begin
        win_d = win_q + 1'b1;
        tok_d = is_tok ? tok_q + 1'b1 : '0;
        if (is_tok && tok_q == TokW'(LockCount - 1)) begin
          state_d = LOCKED;
          tok_d   = '0;
          win_d   = '0;
          run_d   = '0;
        end else if (win_q == WinW'(SearchWindow - 1)) begin
          state_d = SLIP;
          tok_d   = '0;
          win_d   = '0;
        end
      end
      SLIP: begin
        state_d = WAIT;
        wait_d  = '0;
      end
      WAIT: begin
        if (wait_q == WaitW'(SlipWait - 1)) begin
          state_d = SEARCH;
          wait_d  = '0;
          tok_d   = '0;
          win_d   = '0;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      LOCKED: begin
        if (is_tok) begin
          run_d = '0;
        end else if (run_q == RunW'(MaxDataRun - 1)) begin
          state_d = SEARCH;
          run_d   = '0;
          tok_d   = '0;
          win_d   = '0;
        end else begin
          run_d = run_q + 1'b1;
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  assign bitslip_o = (state_q == SLIP);
  assign locked_o  = (state_q == LOCKED);

  // Registered output stage.
  // Pixel data is gated by the state current when the symbol is sampled.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_o <= 8'h00;
      de_o   <= 1'b0;
      ctrl_o <= 2'b00;
    end else if (is_tok) begin
      data_o <= 8'h00;
      de_o   <= 1'b0;
      ctrl_o <= tok_val;
    end else begin
      de_o   <= locked_o;
      data_o <= locked_o ? dec : 8'h00;
    end
  end

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Self-checking bench for tmds_channel_decoder: directed scenarios plus random
// symbols, compared against a timeline model and an encoder-inverse lookup.
module tb_tmds_channel_decoder;

  localparam int LC     = 8;
  localparam int SW     = 4096;
  localparam int SWAIT  = 3;
  localparam int MDR    = 4096;
  localparam int PERIOD = SW + 1 + SWAIT;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] tmds;
  logic       bitslip, locked, de;
  logic [7:0] data;
  logic [1:0] ctrl;

  int vectors     = 0;
  int miscompares = 0;

  tmds_channel_decoder #(
    .LockCount(LC), .SearchWindow(SW), .SlipWait(SWAIT), .MaxDataRun(MDR)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .tmds_i(tmds), .bitslip_o(bitslip),
    .locked_o(locked), .data_o(data), .de_o(de), .ctrl_o(ctrl)
  );

  always #5 clk = ~clk;

  // Decode reference: inverse of the transmit-side transition encoder,
  // indexed by {xor_mode, de-inverted q_m}.
  logic [7:0] inv_tab [512];
  logic [9:0] line_sym [300];

  // Reference state: one timeline counter since SEARCH entry.
  // t < SW is searching, t == SW is the slip pulse, and t > SW is the wait.
  bit         m_lock;
  int         m_t, m_ntok, m_nrun;
  logic [1:0] m_ctrl;
  logic [7:0] m_data;
  bit         m_de;

  function automatic logic [7:0] encode_qm(input logic [7:0] b, input bit xor_mode);
    logic [7:0] q;
    q = '0;
    q[0] = b[0];
    for (int i = 1; i < 8; i++) q[i] = xor_mode ? (q[i-1] ^ b[i]) : ~(q[i-1] ^ b[i]);
    return q;
  endfunction

  function automatic bit is_token(input logic [9:0] s);
    return (s == 10'h354) || (s == 10'h0AB) || (s == 10'h154) || (s == 10'h2AB);
  endfunction

  function automatic logic [1:0] token_val(input logic [9:0] s);
    case (s)
      10'h0AB: return 2'b01;
      10'h154: return 2'b10;
      10'h2AB: return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [9:0] rand_data();
    logic [9:0] s;
    do s = 10'($urandom_range(1023)); while (is_token(s));
    return s;
  endfunction

  // 10-bit window of the serial stream starting at bit c*10+off.
  // Bit 0 of each symbol is the first bit on the wire.
  function automatic logic [9:0] word_at(input int c, input int off);
    logic [9:0] w;
    int q;
    w = '0;
    for (int j = 0; j < 10; j++) begin
      q = c * 10 + off + j;
      w[j] = line_sym[(q / 10) % 300][q % 10];
    end
    return w;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_lock = 0; m_t = 0; m_ntok = 0; m_nrun = 0;
    m_ctrl = 2'b00; m_data = 8'h00; m_de = 0;
  endtask

  task automatic model_step(input logic [9:0] s);
    bit tk;
    tk = is_token(s);
    if (tk) begin
      m_ctrl = token_val(s); m_de = 0; m_data = 8'h00;
    end else begin
      m_de   = m_lock;
      m_data = m_lock ? inv_tab[{s[8], (s[9] ? ~s[7:0] : s[7:0])}] : 8'h00;
    end
    if (m_lock) begin
      if (tk) m_nrun = 0;
      else if (m_nrun == MDR - 1) begin m_lock = 0; m_t = 0; m_ntok = 0; end
      else m_nrun++;
    end else if (m_t < SW) begin
      if (tk && m_ntok == LC - 1) begin m_lock = 1; m_nrun = 0; end
      else begin m_ntok = tk ? m_ntok + 1 : 0; m_t++; end
    end else begin
      m_t++;
      if (m_t == PERIOD) begin m_t = 0; m_ntok = 0; end
    end
  endtask

  task automatic step(input logic [9:0] s);
    tmds = s;
    @(posedge clk);
    model_step(s);
    #1;
    vectors++;
    chk("locked", 32'(locked), 32'(m_lock));
    chk("bitslip", 32'(bitslip), 32'(!m_lock && m_t == SW));
    chk("de", 32'(de), 32'(m_de));
    chk("data", 32'(data), 32'(m_data));
    chk("ctrl", 32'(ctrl), 32'(m_ctrl));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_bitslip", 32'(bitslip), 32'd0);
    chk("rst_de", 32'(de), 32'd0);
    chk("rst_data", 32'(data), 32'd0);
    chk("rst_ctrl", 32'(ctrl), 32'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int         off, c, extra;
    int         slip_at[$];
    logic [9:0] s;

    rst_n = 1'b1;
    tmds  = 10'h000;
    for (int m = 0; m < 2; m++)
      for (int b = 0; b < 256; b++)
        inv_tab[{m[0], encode_qm(8'(b), m[0])}] = 8'(b);

    #2 do_reset();

    // Aligned lock, then three data symbols with known decodes.
    for (int i = 0; i < LC; i++) begin
      step(10'h354);
      if (i == LC - 2) chk("lock_before_8th", 32'(locked), 32'd0);
    end
    chk("lock_after_8th", 32'(locked), 32'd1);
    step(10'h100); chk("d100", 32'({de, data}), 32'h100);
    step(10'h1FF); chk("d1ff", 32'({de, data}), 32'h101);
    step(10'h2FF); chk("d2ff", 32'({de, data}), 32'h1FE);
    chk("ctrl00", 32'(ctrl), 32'd0);

    // Control value is held across a data burst.
    step(10'h0AB);
    chk("hold_tok_ctrl", 32'(ctrl), 32'd1);
    chk("hold_tok_de", 32'(de), 32'd0);
    for (int i = 0; i < 5; i++) begin
      step(rand_data());
      chk("hold_ctrl", 32'(ctrl), 32'd1);
      chk("hold_de", 32'(de), 32'd1);
    end
    step(10'h2AB);
    chk("ctrl11", 32'(ctrl), 32'd3);
    chk("ctrl11_de", 32'(de), 32'd0);

    // Random locked traffic with mixed tokens.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(9) < 3) begin
        case ($urandom_range(3))
          0: s = 10'h354;
          1: s = 10'h0AB;
          2: s = 10'h154;
          default: s = 10'h2AB;
        endcase
      end else begin
        s = rand_data();
      end
      step(s);
    end

    // Asynchronous reset mid-stream while locked.
    do_reset();

    // An interrupted token run must not lock.
    for (int i = 0; i < LC - 1; i++) step(10'h354);
    step(10'h100);
    chk("intr_no_de", 32'(de), 32'd0);
    chk("intr_unlocked", 32'(locked), 32'd0);
    for (int i = 0; i < LC; i++) begin
      step(10'h354);
      if (i == LC - 2) chk("intr_before", 32'(locked), 32'd0);
    end
    chk("intr_locked", 32'(locked), 32'd1);

    // Lock loss after MDR consecutive data symbols, then one search window to slip.
    for (int i = 1; i <= MDR; i++) begin
      step(10'h100);
      if (i == MDR - 1) chk("loss_before", 32'(locked), 32'd1);
    end
    chk("loss_locked", 32'(locked), 32'd0);
    chk("loss_last_de", 32'(de), 32'd1);
    step(10'h100);
    chk("loss_de_gated", 32'(de), 32'd0);
    for (int j = 2; j <= SW; j++) begin
      step(10'h100);
      if (j == SW - 1) chk("loss_no_slip_yet", 32'(bitslip), 32'd0);
    end
    chk("loss_slip", 32'(bitslip), 32'd1);
    for (int j = 0; j < 4; j++) step(10'h100);

    // Misaligned stream, 3-bit rotation, one bit per slip: seven slips required.
    do_reset();
    for (int i = 0; i < 300; i++) line_sym[i] = (i >= 200) ? 10'h354 : rand_data();
    off = 3;
    c   = 0;
    while (!locked && c < 10 * PERIOD) begin
      step(word_at(c, off));
      c++;
      if (bitslip) begin
        slip_at.push_back(c);
        off = (off + 1) % 10;
      end
    end
    chk("mis_locked", 32'(locked), 32'd1);
    chk("mis_slips", 32'(slip_at.size()), 32'd7);
    if (slip_at.size() > 0) chk("mis_first_slip", 32'(slip_at[0]), 32'(SW));
    for (int i = 1; i < slip_at.size(); i++)
      chk("mis_spacing", 32'(slip_at[i] - slip_at[i-1]), 32'(PERIOD));
    extra = 0;
    for (int i = 0; i < 600; i++) begin
      step(word_at(c, off));
      c++;
      if (bitslip) extra++;
    end
    chk("mis_no_more_slips", 32'(extra), 32'd0);
    chk("mis_still_locked", 32'(locked), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
